// File: rtl/mux_arbitrado_n.sv
// mux_arbitrado_n: N-way valid/ready channel mux with a one-entry output register.
// Channel chosen by explicit selector (MODO=0) or round-robin scan (MODO=1).
module mux_arbitrado_n #(
    parameter int ANCHO      = 32,
    parameter int N_ENTRADAS = 4,
    parameter int SEL_W      = $clog2(N_ENTRADAS),
    parameter int MODO       = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [SEL_W-1:0]            selectorMUX,
    input  logic [N_ENTRADAS*ANCHO-1:0] entrada_datos,
    input  logic [N_ENTRADAS-1:0]       entrada_valid,
    output logic [N_ENTRADAS-1:0]       entrada_ready,
    output logic [ANCHO-1:0]            salida_datos,
    output logic [SEL_W-1:0]            salida_canal,
    output logic                        salida_valid,
    input  logic                        salida_ready
);

    logic             valid_q, valid_d;
    logic [ANCHO-1:0] datos_q, datos_d;
    logic [SEL_W-1:0] canal_q, canal_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             carga;
    logic             hay;
    logic             xfer;
    logic [SEL_W-1:0] elegido;
    logic [SEL_W-1:0] idx;
    logic [ANCHO-1:0] dato_sel;

    assign carga = !reset && !flush && (!valid_q || salida_ready);

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        elegido = selectorMUX;
        hay     = 1'b1;
        idx     = '0;
        if (MODO == 1) begin
            elegido = '0;
            hay     = 1'b0;
            for (int k = N_ENTRADAS - 1; k >= 0; k--) begin
                idx = ptr_q + SEL_W'(k);
                if (entrada_valid[idx]) begin
                    elegido = idx;
                    hay     = 1'b1;
                end
            end
        end
    end

    assign dato_sel = entrada_datos[elegido*ANCHO +: ANCHO];
    assign xfer     = carga && hay && entrada_valid[elegido];

    always_comb begin
        entrada_ready = '0;
        if (carga && hay) begin
            entrada_ready[elegido] = 1'b1;
        end
    end

    always_comb begin
        valid_d = valid_q;
        datos_d = datos_q;
        canal_d = canal_q;
        ptr_d   = ptr_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (carga) begin
            valid_d = xfer;
            if (xfer) begin
                datos_d = dato_sel;
                canal_d = elegido;
                if (MODO == 1) begin
                    ptr_d = elegido + SEL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            datos_q <= '0;
            canal_q <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            datos_q <= datos_d;
            canal_q <= canal_d;
            ptr_q   <= ptr_d;
        end
    end

    assign salida_valid = valid_q;
    assign salida_datos = datos_q;
    assign salida_canal = canal_q;

endmodule

// File: tb/tb_mux_arbitrado_n.sv
// tb_mux_arbitrado_n: selector-mode and round-robin-mode instances side by side,
// directed sequences, a vector table and randomized traffic against a reference model.
module tb_mux_arbitrado_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        fl   [2];
    logic [1:0]  sel  [2];
    logic [127:0] dat [2];
    logic [3:0]  v    [2];
    logic [3:0]  rdy  [2];
    logic [31:0] so_d [2];
    logic [1:0]  so_c [2];
    logic        so_v [2];
    logic        sr   [2];

    int tests = 0;
    int fails = 0;

    logic        mv [2];
    logic [31:0] md [2];
    int          mc [2];
    int          mp [2];
    logic [3:0]  er [2];
    logic [3:0]  cr [2];

    typedef struct {
        logic [3:0]  v;
        logic        sr;
        logic [3:0]  e_rdy;
        logic        e_val;
        logic [1:0]  e_can;
        logic [31:0] e_dat;
    } vec_t;
    vec_t tbl [12];

    always #5 clk = ~clk;

    mux_arbitrado_n #(.ANCHO(32), .N_ENTRADAS(4), .MODO(0)) u0 (
        .clk(clk), .reset(rst), .flush(fl[0]), .selectorMUX(sel[0]),
        .entrada_datos(dat[0]), .entrada_valid(v[0]), .entrada_ready(rdy[0]),
        .salida_datos(so_d[0]), .salida_canal(so_c[0]),
        .salida_valid(so_v[0]), .salida_ready(sr[0])
    );

    mux_arbitrado_n #(.ANCHO(32), .N_ENTRADAS(4), .MODO(1)) u1 (
        .clk(clk), .reset(rst), .flush(fl[1]), .selectorMUX(sel[1]),
        .entrada_datos(dat[1]), .entrada_valid(v[1]), .entrada_ready(rdy[1]),
        .salida_datos(so_d[1]), .salida_canal(so_c[1]),
        .salida_valid(so_v[1]), .salida_ready(sr[1])
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    function automatic logic [3:0] m_rdy(input int m);
        logic carga;
        bit   has;
        int   ch;
        carga = !rst && !fl[m] && (!mv[m] || sr[m]);
        has = 0;
        ch  = 0;
        if (m == 0) begin
            ch  = int'(sel[0]);
            has = 1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!has && v[1][(mp[1] + k) % 4]) begin
                    ch  = (mp[1] + k) % 4;
                    has = 1;
                end
            end
        end
        return (carga && has) ? 4'(1 << ch) : 4'b0000;
    endfunction

    task automatic m_step(input int m);
        logic [3:0] r;
        int ch;
        r = m_rdy(m);
        ch = 0;
        for (int i = 0; i < 4; i++) if (r[i]) ch = i;
        if (rst) begin
            mv[m] = 0; md[m] = 0; mc[m] = 0; mp[m] = 0;
        end else if ((r & v[m]) != 4'b0000) begin
            mv[m] = 1;
            md[m] = dat[m][ch*32 +: 32];
            mc[m] = ch;
            if (m == 1) mp[m] = (ch + 1) % 4;
        end else if (fl[m] || sr[m]) begin
            mv[m] = 0;
        end
    endtask

    task automatic tick();
        #1;
        for (int m = 0; m < 2; m++) begin
            cr[m] = rdy[m];
            er[m] = m_rdy(m);
            m_step(m);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h10};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h11};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h12};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'h13};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h10};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h11};
        tbl[6]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h12};
        tbl[7]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h11};
        tbl[8]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h12};
        tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 32'h12};
        tbl[10] = '{4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 32'h13};
        tbl[11] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, 32'h13};

        for (int m = 0; m < 2; m++) begin
            fl[m] = 0; sel[m] = 0; dat[m] = '0; v[m] = 4'b1111; sr[m] = 1;
            mv[m] = 0; md[m] = 0; mc[m] = 0; mp[m] = 0;
        end
        rst = 1;
        tick();
        chk("rst_rdy0", cr[0], 4'b0000);
        chk("rst_rdy1", cr[1], 4'b0000);
        chk("rst_val0", so_v[0], 0);
        chk("rst_dat0", so_d[0], 0);
        chk("rst_can0", so_c[0], 0);
        chk("rst_val1", so_v[1], 0);

        rst = 0;
        v[1] = 4'b0000;
        sel[0] = 2; v[0] = 4'b0100; sr[0] = 1;
        dat[0] = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
        tick();
        chk("m0_rdy", cr[0], 4'b0100);
        chk("m0_val", so_v[0], 1);
        chk("m0_dat", so_d[0], 32'hCAFE0002);
        chk("m0_can", so_c[0], 2);

        sr[0] = 0; v[0] = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            sel[0] = (i == 0) ? 2'd1 : 2'd3;
            tick();
            chk("hold_rdy", cr[0], 4'b0000);
            chk("hold_val", so_v[0], 1);
            chk("hold_dat", so_d[0], 32'hCAFE0002);
            chk("hold_can", so_c[0], 2);
        end
        sr[0] = 1;
        tick();
        chk("rel_rdy", cr[0], 4'b1000);
        chk("rel_dat", so_d[0], 32'hCAFE0003);
        chk("rel_can", so_c[0], 3);

        v[0] = 4'b0000;
        dat[1] = {32'h13, 32'h12, 32'h11, 32'h10};
        for (int i = 0; i < 12; i++) begin
            v[1] = tbl[i].v;
            sr[1] = tbl[i].sr;
            tick();
            chk($sformatf("tbl%0d_rdy", i), cr[1], tbl[i].e_rdy);
            chk($sformatf("tbl%0d_val", i), so_v[1], tbl[i].e_val);
            chk($sformatf("tbl%0d_can", i), so_c[1], tbl[i].e_can);
            chk($sformatf("tbl%0d_dat", i), so_d[1], tbl[i].e_dat);
        end

        fl[1] = 1; sr[1] = 1; v[1] = 4'b1111;
        tick();
        chk("fl_rdy", cr[1], 4'b0000);
        chk("fl_val", so_v[1], 0);
        chk("fl_can", so_c[1], 3);
        chk("fl_dat", so_d[1], 32'h13);
        fl[1] = 0;
        tick();
        chk("postfl_rdy", cr[1], 4'b0001);
        chk("postfl_val", so_v[1], 1);
        chk("postfl_can", so_c[1], 0);

        sr[0] = 1; v[0] = 4'b0001; sel[0] = 0;
        tick();
        sr[0] = 0;
        tick();
        chk("pre_rst_val", so_v[0], 1);
        rst = 1;
        tick();
        chk("mid_rst_rdy0", cr[0], 4'b0000);
        chk("mid_rst_rdy1", cr[1], 4'b0000);
        chk("mid_rst_val", so_v[0], 0);
        chk("mid_rst_dat", so_d[0], 0);
        chk("mid_rst_can", so_c[0], 0);
        sr[0] = 1;
        tick();
        chk("mid_rst2_rdy0", cr[0], 4'b0000);
        chk("mid_rst2_rdy1", cr[1], 4'b0000);
        rst = 0;
        tick();
        chk("post_rst_ptr", cr[1], 4'b0001);
        chk("post_rst_can", so_c[1], 0);

        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) < 3);
            for (int m = 0; m < 2; m++) begin
                fl[m]  = ($urandom_range(0, 99) < 10);
                sel[m] = 2'($urandom_range(0, 3));
                v[m]   = 4'($urandom_range(0, 15));
                sr[m]  = ($urandom_range(0, 99) < 70);
                dat[m] = {$urandom, $urandom, $urandom, $urandom};
            end
            tick();
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("rnd%0d_rdy%0d", n, m), cr[m], er[m]);
                chk($sformatf("rnd%0d_val%0d", n, m), so_v[m], mv[m]);
                chk($sformatf("rnd%0d_dat%0d", n, m), so_d[m], md[m]);
                chk($sformatf("rnd%0d_can%0d", n, m), so_c[m], 32'(mc[m]));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_arbitrado_n.md
Name: mux_arbitrado_n

Overview:
- Parametrised successor to the pipeline 2:1 datapath mux. Selects one of N_ENTRADAS channels, each ANCHO bits wide, onto a single registered output with valid/ready handshakes on every side.
- Selection is either by an explicit selector (MODO=0) or by a round-robin arbiter (MODO=1).
- Used where several producers share one pipeline consumer, e.g. write-back sources or debug/memory ports. A one-entry output register breaks the combinational path.

Parameters:
- ANCHO, 32, data width per channel in bits.
- N_ENTRADAS, 4, number of input channels. Must be a power of two, >= 2.
- SEL_W, log2(N_ENTRADAS), selector and channel-index width. Derived; not overridden.
- MODO, 0, selection mode: 0 = explicit selector, 1 = round-robin.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush; discards the held output beat.
- selectorMUX  in  SEL_W  channel select. Used only when MODO=0.
- entrada_datos  in  N_ENTRADAS*ANCHO  concatenated channel data; channel i occupies bits [i*ANCHO +: ANCHO].
- entrada_valid  in  N_ENTRADAS  per-channel valid.
- entrada_ready  out  N_ENTRADAS  per-channel ready (combinational).
- salida_datos  out  ANCHO  registered output data.
- salida_canal  out  SEL_W  index of the channel that produced salida_datos.
- salida_valid  out  1  output beat valid.
- salida_ready  in  1  consumer ready.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: salida_valid=0, salida_datos=0, salida_canal=0, round-robin pointer ptr=0. entrada_ready is all 0 while reset=1.
- Load enable: carga = !reset && !flush && (!salida_valid || salida_ready).
- Channel choice, MODO=0: elegido = selectorMUX.
- Channel choice, MODO=1: elegido = first i with entrada_valid[i]=1, scanning ptr, ptr+1, ..., wrapping modulo N_ENTRADAS. If no channel is valid, there is no candidate.
- Ready: entrada_ready[i] = carga && (i == elegido) && candidate exists. At most one ready bit is high in any cycle.
  - MODO=0: ready for the selected channel does not depend on its valid.
  - MODO=1: all ready bits are 0 when no channel is valid.
- Transfer: channel i transfers when entrada_valid[i] && entrada_ready[i].
- On transfer, next edge: salida_datos <= channel data, salida_canal <= i, salida_valid <= 1.
- Latency: 1 cycle from input acceptance to salida_valid.
- Throughput: one beat per cycle while salida_ready=1.
- Drain: if carga=1 but there is no transfer (no valid on the chosen channel), salida_valid <= 0 and salida_datos/salida_canal hold their values.
- Hold: when salida_valid=1 and salida_ready=0, all outputs are stable and all entrada_ready bits are 0 (backpressure).
- Round-robin pointer (MODO=1 only): on a transfer from channel k, ptr <= (k+1) mod N_ENTRADAS (natural SEL_W wrap). With no transfer, ptr holds. In MODO=0, ptr stays 0.
- Flush: next edge salida_valid <= 0. No input is accepted in the flush cycle. ptr, salida_datos and salida_canal hold.
- Priority: reset beats flush, flush beats transfer.
- Reset mid-operation: the held beat is lost, and no input is accepted during reset. The first possible acceptance is the cycle after reset deasserts.
- MODO=0 selector change while the output is held: no effect until carga=1. The selector is sampled only in load cycles.
- All indices are unsigned; the selector cannot be out of range because N_ENTRADAS is a power of two.

Test Plan:
- Reset, then MODO=0, N=4, selectorMUX=2, entrada_valid=4'b0100, data ch2=0xCAFE0002, salida_ready=1 -> entrada_ready=4'b0100. Next cycle: salida_valid=1, salida_datos=0xCAFE0002, salida_canal=2.
- MODO=0, hold salida_ready=0 with a beat held; change selectorMUX 1->3 -> entrada_ready=0. Outputs stay stable for 5 cycles. After salida_ready=1, the next beat comes from ch3.
- MODO=1, all four channels continuously valid (data ch_i = 0x10+i), salida_ready=1 -> salida_canal sequence 0,1,2,3,0,1 and salida_datos 0x10,0x11,0x12,0x13,0x10,0x11.
- MODO=1, ptr=3, only ch1 valid -> ch1 is accepted (scan wraps 3->0->1). ptr becomes 2. Next grant with all channels valid goes to ch2.
- Flush asserted in the same cycle as valid input, with salida_valid=1 -> no entrada_ready. Next cycle salida_valid=0 and ptr unchanged. Following cycle the beat is accepted normally.
- Assert reset while salida_valid=1 and salida_ready=0 -> next edge: salida_valid=0, salida_datos=0, salida_canal=0, ptr=0. entrada_ready=0 throughout reset.
